// File: rtl/mips_uart_tx_port.sv
// Memory-mapped UART transmitter for the MIPS data-memory stage: a byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mips_uart_tx_port #(
  parameter int unsigned CLK_DIV     = 434,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] TX_ADDR     = 32'h1001_0024,
  parameter logic [31:0] STATUS_ADDR = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        TxD,
  output logic        Busy,
  output logic        IrqTxEmpty
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic       fifo_empty, fifo_full, push_req, push_ok, pop, ctrl_clr, baud_done;
  logic [6:0] count_wide;
  logic [3:0] count_sat;
  logic       unused_wdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_req   = MemWrite && (Address == TX_ADDR);
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A full FIFO still takes a byte when the serialiser frees a slot on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ctrl_clr   = MemWrite && (Address == STATUS_ADDR) && WriteData[3];
  assign baud_done  = (baud_q == '0);
  assign unused_wdata = ^WriteData[31:8];

  assign Busy       = (state_q != IDLE);
  assign IrqTxEmpty = fifo_empty && !Busy;

  assign count_wide = 7'(count_q);
  assign count_sat  = (count_wide > 7'd15) ? 4'hF : count_wide[3:0];
  assign ReadData   = (MemRead && (Address == STATUS_ADDR))
                    ? {24'b0, count_sat, overflow_q, Busy, fifo_full, fifo_empty}
                    : 32'b0;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    // A drop on the same edge as a clear leaves the flag set.
    if (push_req && !push_ok) overflow_d = 1'b1;
    else if (ctrl_clr)        overflow_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    TxD       = 1'b1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = fifo_q[rd_ptr_q];
          baud_d    = BAUD_RELOAD;
          bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_q[rd_ptr_q];
`endif
          state_d   = START;
        end
      end
      START: begin
        TxD = 1'b0;
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        TxD = shift_q[0];
        if (baud_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TxD = parity_q;
        if (baud_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) baud_d = baud_done ? BAUD_RELOAD : baud_q - 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_uart_tx_port.sv
// Bench for mips_uart_tx_port: a line monitor decodes frames into a queue that is
// scoreboarded against bytes pushed at store time, plus cycle-exact waveform checks.
module tb_mips_uart_tx_port;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam logic [31:0] TX_ADDR     = 32'h1001_0024;
  localparam logic [31:0] STATUS_ADDR = 32'h1001_0028;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        TxD, Busy, IrqTxEmpty;

  int checks = 0;
  int passes = 0;

  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  logic       rxStopQ[$];
  logic       rxParQ[$];
  int         resetCount = 0;

  mips_uart_tx_port #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH),
    .TX_ADDR(TX_ADDR), .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .TxD(TxD), .Busy(Busy), .IrqTxEmpty(IrqTxEmpty)
  );

  always #5 clk = ~clk;

  always @(posedge reset) resetCount = resetCount + 1;

  // Line monitor: samples mid-bit, drops any frame that a reset interrupted.
  initial begin : monitor
    logic [7:0] b;
    logic       p, s;
    int         rc;
    forever begin
      @(negedge clk);
      if (TxD === 1'b0 && reset === 1'b0) begin
        rc = resetCount;
        b  = '0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[j] = TxD;
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        p = TxD;
`endif
        repeat (CLK_DIV) @(negedge clk);
        s = TxD;
        if (rc == resetCount) begin
          rxQ.push_back(b);
          rxParQ.push_back(p);
          rxStopQ.push_back(s);
        end
      end
    end
  end

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWrite = 1'b1; Address = addr; WriteData = data;
    @(negedge clk);
    MemWrite = 1'b0; Address = '0; WriteData = '0;
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 20 * FRAME; w++) begin
      @(negedge clk);
      if (IrqTxEmpty === 1'b1 && rxQ.size() == expQ.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (CLK_DIV * NBITS) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (TxD !== 1'b1) $display("[TB] FAIL reset_txd: got %b expected 1", TxD); else passes++;
    checks++; if (Busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", Busy); else passes++;
    checks++; if (IrqTxEmpty !== 1'b1) $display("[TB] FAIL reset_irq: got %b expected 1", IrqTxEmpty); else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h1) $display("[TB] FAIL reset_status: got %h expected %h", ReadData, 32'h1); else passes++;
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic test_single_frame;
    logic [7:0] d;
    logic       got, exp;
    bit         ok;
    d = 8'hA5;
    expQ.push_back(d);
    storeWord(TX_ADDR, 32'hFFFF_FFA5);
    checks++; if (TxD !== 1'b1) $display("[TB] FAIL latency_txd: got %b expected 1", TxD); else passes++;
    checks++; if (IrqTxEmpty !== 1'b0) $display("[TB] FAIL latency_irq: got %b expected 0", IrqTxEmpty); else passes++;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp = frameBit(d, i / CLK_DIV);
      got = TxD;
      checks++; if (got !== exp) $display("[TB] FAIL frame_txd[%0d]: got %b expected %b", i, got, exp); else passes++;
      checks++; if (Busy !== 1'b1) $display("[TB] FAIL frame_busy[%0d]: got %b expected 1", i, Busy); else passes++;
    end
    @(negedge clk);
    checks++; if (Busy !== 1'b0) $display("[TB] FAIL frame_end_busy: got %b expected 0", Busy); else passes++;
    checks++; if (IrqTxEmpty !== 1'b1) $display("[TB] FAIL frame_end_irq: got %b expected 1", IrqTxEmpty); else passes++;
    waitIdle(ok);
    checks++; if (!ok) $display("[TB] FAIL single_timeout: got %0d frames expected %0d", rxQ.size(), expQ.size()); else passes++;
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      d = expQ.pop_front();
      checks++; if (rxQ[0] !== d) $display("[TB] FAIL single_byte: got %h expected %h", rxQ[0], d); else passes++;
      checks++; if (rxStopQ[0] !== 1'b1) $display("[TB] FAIL single_stop: got %b expected 1", rxStopQ[0]); else passes++;
      void'(rxQ.pop_front()); void'(rxStopQ.pop_front()); void'(rxParQ.pop_front());
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    bit         ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      MemWrite = 1'b1; Address = TX_ADDR;
      WriteData = $urandom();
      WriteData[7:0] = 8'h30 + 8'(i);
      if (i < 9) expQ.push_back(8'h30 + 8'(i));
    end
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h8E) $display("[TB] FAIL ovf_status: got %h expected %h", ReadData, 32'h8E); else passes++;
    MemRead = 1'b0;
    storeWord(STATUS_ADDR, 32'hFFFF_FFF7);
    MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h8E) $display("[TB] FAIL ovf_noclear: got %h expected %h", ReadData, 32'h8E); else passes++;
    MemRead = 1'b0;
    storeWord(STATUS_ADDR, 32'h8);
    MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h86) $display("[TB] FAIL ovf_clear: got %h expected %h", ReadData, 32'h86); else passes++;
    MemRead = 1'b0; Address = '0;
    waitIdle(ok);
    checks++; if (!ok) $display("[TB] FAIL ovf_timeout: got %0d frames expected %0d", rxQ.size(), expQ.size()); else passes++;
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      d = expQ.pop_front();
      checks++; if (rxQ[0] !== d) $display("[TB] FAIL ovf_byte: got %h expected %h", rxQ[0], d); else passes++;
      checks++; if (rxStopQ[0] !== 1'b1) $display("[TB] FAIL ovf_stop: got %b expected 1", rxStopQ[0]); else passes++;
      void'(rxQ.pop_front()); void'(rxStopQ.pop_front()); void'(rxParQ.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic       exp, expBusy;
    bit         ok;
    expQ.push_back(8'h55);
    expQ.push_back(8'hAA);
    @(negedge clk);
    MemWrite = 1'b1; Address = TX_ADDR; WriteData = 32'h55;
    @(negedge clk);
    WriteData = 32'hAA;
    @(negedge clk);
    MemWrite = 1'b0; Address = '0; WriteData = '0;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i < FRAME) begin
        exp = frameBit(8'h55, i / CLK_DIV); expBusy = 1'b1;
      end else if (i == FRAME) begin
        exp = 1'b1; expBusy = 1'b0;
      end else begin
        exp = frameBit(8'hAA, (i - FRAME - 1) / CLK_DIV); expBusy = 1'b1;
      end
      checks++; if (TxD !== exp) $display("[TB] FAIL b2b_txd[%0d]: got %b expected %b", i, TxD, exp); else passes++;
      checks++; if (Busy !== expBusy) $display("[TB] FAIL b2b_busy[%0d]: got %b expected %b", i, Busy, expBusy); else passes++;
      @(negedge clk);
    end
    waitIdle(ok);
    checks++; if (!ok) $display("[TB] FAIL b2b_timeout: got %0d frames expected %0d", rxQ.size(), expQ.size()); else passes++;
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      d = expQ.pop_front();
      checks++; if (rxQ[0] !== d) $display("[TB] FAIL b2b_byte: got %h expected %h", rxQ[0], d); else passes++;
      void'(rxQ.pop_front()); void'(rxStopQ.pop_front()); void'(rxParQ.pop_front());
    end
  endtask

  task automatic test_reset_midframe;
    storeWord(TX_ADDR, 32'h0000_00F0);
    repeat (4 * CLK_DIV + 2) @(negedge clk);
    checks++; if (TxD !== 1'b0) $display("[TB] FAIL mid_bit3: got %b expected 0", TxD); else passes++;
    checks++; if (Busy !== 1'b1) $display("[TB] FAIL mid_busy: got %b expected 1", Busy); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (TxD !== 1'b1) $display("[TB] FAIL rst_txd: got %b expected 1", TxD); else passes++;
    checks++; if (Busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", Busy); else passes++;
    checks++; if (IrqTxEmpty !== 1'b1) $display("[TB] FAIL rst_irq: got %b expected 1", IrqTxEmpty); else passes++;
    MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h1) $display("[TB] FAIL rst_status: got %h expected %h", ReadData, 32'h1); else passes++;
    MemRead = 1'b0; Address = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (FRAME + 8) @(negedge clk);
    checks++; if (rxQ.size() != 0) $display("[TB] FAIL rst_noframe: got %0d frames expected 0", rxQ.size()); else passes++;
  endtask

  task automatic test_address_decode;
    bit lineQuiet;
    @(negedge clk);
    MemRead = 1'b1; Address = TX_ADDR;
    #1;
    checks++; if (ReadData !== 32'h0) $display("[TB] FAIL rd_txaddr: got %h expected 0", ReadData); else passes++;
    Address = 32'h1001_0000;
    #1;
    checks++; if (ReadData !== 32'h0) $display("[TB] FAIL rd_unmapped: got %h expected 0", ReadData); else passes++;
    MemRead = 1'b0; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h0) $display("[TB] FAIL rd_noread: got %h expected 0", ReadData); else passes++;
    Address = '0;
    storeWord(32'h1001_0020, 32'h0000_00AB);
    storeWord(32'h1001_0025, 32'h0000_00CD);
    lineQuiet = 1'b1;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Busy !== 1'b0) lineQuiet = 1'b0;
    end
    checks++; if (!lineQuiet) $display("[TB] FAIL wr_unmapped_line: got active expected idle"); else passes++;
    MemRead = 1'b1; Address = STATUS_ADDR;
    #1;
    checks++; if (ReadData !== 32'h1) $display("[TB] FAIL wr_unmapped_status: got %h expected %h", ReadData, 32'h1); else passes++;
    MemRead = 1'b0; Address = '0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] d;
    logic       exp;
    bit         ok;
    d = 8'h07;
    expQ.push_back(d);
    storeWord(TX_ADDR, 32'h0000_0007);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp = frameBit(d, i / CLK_DIV);
      checks++; if (TxD !== exp) $display("[TB] FAIL par_txd[%0d]: got %b expected %b", i, TxD, exp); else passes++;
    end
    @(negedge clk);
    checks++; if (Busy !== 1'b0) $display("[TB] FAIL par_len: got %b expected 0", Busy); else passes++;
    waitIdle(ok);
    checks++; if (!ok) $display("[TB] FAIL par_timeout: got %0d frames expected %0d", rxQ.size(), expQ.size()); else passes++;
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      d = expQ.pop_front();
      checks++; if (rxQ[0] !== d) $display("[TB] FAIL par_byte: got %h expected %h", rxQ[0], d); else passes++;
      checks++; if (rxParQ[0] !== 1'b1) $display("[TB] FAIL par_bit: got %b expected 1", rxParQ[0]); else passes++;
      void'(rxQ.pop_front()); void'(rxStopQ.pop_front()); void'(rxParQ.pop_front());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_address_decode();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
